reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of write requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter ADDR_W, default 5, giving the register-address width.
REQ-003 SHALL have parameter DATA_W, default 32, giving the write-data width.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Stall, input, 1 bit: pipeline stall; freezes arbitration.
REQ-007 SHALL have port Req, input, 4 bits: per-requester write request.
REQ-008 SHALL have port ReqAddr, input, 4x5 bits: per-requester destination register.
REQ-009 SHALL have port ReqData, input, 4x32 bits: per-requester write data.
REQ-010 SHALL have port Gnt, output, 4 bits: one-hot combinational grant.
REQ-011 SHALL have port Sel, output, 2 bits: registered index of the last granted requester, driving the downstream address/data 4-to-1 muxes.
REQ-012 SHALL have port WrEn, output, 1 bit: registered register-file write enable.
REQ-013 SHALL have port WrAddr, output, 5 bits: registered register-file write address.
REQ-014 SHALL have port WrData, output, 32 bits: registered register-file write data.

Function
REQ-015 SHALL hold a 2-bit round-robin pointer Ptr naming the highest-priority requester.
REQ-016 SHALL, when Stall=0 and Req is nonzero, assert Gnt for exactly one requester: the first set bit of Req searched in order Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4).
REQ-017 SHALL drive Gnt=0 whenever Stall=1 or Req=0.
REQ-018 SHALL define a transfer as Req[i]&Gnt[i] at a rising Clk edge; requesters hold Req, ReqAddr and ReqData stable until their transfer.
REQ-019 SHALL, on a transfer from requester i, load Sel=i, WrAddr=ReqAddr[i], WrData=ReqData[i] at that edge (write port latency 1 cycle).
REQ-020 SHALL set WrEn=1 on a transfer unless ReqAddr[i]=0, in which case WrEn=0 (register $zero never written), but the transfer still completes.
REQ-021 SHALL set WrEn=0 on any edge without a transfer; Sel, WrAddr and WrData hold their previous values.
REQ-022 SHALL, on a transfer from i, update Ptr to (i+1) mod 4 (wrap 3->0); Ptr holds otherwise.
REQ-023 SHALL, under Stall=1, hold Ptr and deassert WrEn on the following edge.
REQ-024 SHALL guarantee that any continuously asserted Req is granted within 4 unstalled cycles.
REQ-025 SHALL not detect duplicate destination addresses across requesters; each transfer writes in grant order.

Reset
REQ-026 SHALL, while Rst=0, asynchronously force Ptr=0, Sel=0, WrEn=0, WrAddr=0, WrData=0.
REQ-027 SHALL discard any write registered but not yet consumed when Rst asserts mid-operation; Gnt is 0 while Rst=0.
REQ-028 SHALL resume arbitration on the first rising edge after Rst deasserts, starting from priority 0.

Structure
REQ-029 SHALL place NUM_REQ, ADDR_W, DATA_W and the zero-register constant (5'd0) in the shared processor constants package.
REQ-030 SHALL implement grant selection in one combinational sub-module, rr_priority_pick (inputs Req, Ptr; outputs one-hot Gnt and 2-bit index).
REQ-031 SHALL keep all sequential state (Ptr and the write-port registers) in reg_write_arbiter.

Verification
REQ-032 Reset: Rst=0 with Req=4'b1111 -> Gnt=0, WrEn=0, Sel=0, WrAddr=0, WrData=0; after release, the first grant goes to requester 0.
REQ-033 Rotation: Req=4'b1111 held for 5 cycles -> grant order 0,1,2,3,0; Sel follows one cycle later.
REQ-034 Single write: Req=4'b0100, ReqAddr[2]=5'd9, ReqData[2]=32'hDEADBEEF -> next cycle WrEn=1, WrAddr=9, WrData=DEADBEEF, Sel=2, Ptr=3.
REQ-035 Zero register: Req=4'b0010, ReqAddr[1]=0 -> Gnt=4'b0010 and transfer completes, next cycle WrEn=0, Ptr=2.
REQ-036 Stall: Req=4'b1000 with Stall=1 for 3 cycles -> Gnt=0, WrEn=0, Ptr unchanged; on Stall=0, granted in the same cycle.
REQ-037 Reset mid-write: Rst pulsed low the cycle after a grant with WrEn=1 -> WrEn=0 immediately, Ptr=0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared processor constants for the register-file write arbiter.
package reg_write_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 2;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // Round-robin successor of a granted index; wraps naturally in IDX_W bits.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction
endpackage

// File: rtl/reg_write_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_i + IDX_W'(k);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter funnelling four write requesters into one register-file write port.
module reg_write_arbiter #(
    parameter int NUM_REQ = reg_write_arbiter_pkg::NUM_REQ,
    parameter int ADDR_W  = reg_write_arbiter_pkg::ADDR_W,
    parameter int DATA_W  = reg_write_arbiter_pkg::DATA_W
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Stall,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]             Gnt,
    output logic [$clog2(NUM_REQ)-1:0]     Sel,
    output logic                           WrEn,
    output logic [ADDR_W-1:0]              WrAddr,
    output logic [DATA_W-1:0]              WrData
);
    import reg_write_arbiter_pkg::*;

    localparam int SEL_W = $clog2(NUM_REQ);

    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] req_eff;
    logic [SEL_W-1:0]   pick_idx;
    logic               xfer;

    // Stall and reset mask requests before the pick, so Gnt drops to zero without extra gating.
    assign req_eff = Req & {NUM_REQ{~Stall & Rst}};

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SEL_W)
    ) u_pick (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (Gnt),
        .idx_o (pick_idx)
    );

    assign xfer = |Gnt;

    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = next_ptr(pick_idx);
            sel_d     = pick_idx;
            wr_addr_d = ReqAddr[pick_idx];
            wr_data_d = ReqData[pick_idx];
            // A write aimed at $zero still consumes the grant, it just never reaches the file.
            wr_en_d   = (ReqAddr[pick_idx] != ZERO_REG);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr_q     <= '0;
            sel_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign Sel    = sel_q;
    assign WrEn   = wr_en_q;
    assign WrAddr = wr_addr_q;
    assign WrData = wr_data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, rotation, single write, $zero, stall, mid-write reset.
module tb_reg_write_arbiter;
    logic            Clk;
    logic            Rst;
    logic            Stall;
    logic [3:0]      Req;
    logic [3:0][4:0] ReqAddr;
    logic [3:0][31:0] ReqData;
    logic [3:0]      Gnt;
    logic [1:0]      Sel;
    logic            WrEn;
    logic [4:0]      WrAddr;
    logic [31:0]     WrData;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Stall   (Stall),
        .Req     (Req),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .Gnt     (Gnt),
        .Sel     (Sel),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        int         idx;

        Rst     = 1'b0;
        Stall   = 1'b0;
        Req     = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ReqAddr[i] = 5'(i + 1);
            ReqData[i] = 32'hA0 + 32'(i);
        end

        // Reset held with all requesters active
        tick();
        tick();
        chk("rst_gnt",    32'(Gnt),    32'h0);
        chk("rst_wren",   32'(WrEn),   32'h0);
        chk("rst_sel",    32'(Sel),    32'h0);
        chk("rst_waddr",  32'(WrAddr), 32'h0);
        chk("rst_wdata",  WrData,      32'h0);
        chk("rst_ptr",    32'(dut.ptr_q), 32'h0);

        Rst = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(Gnt), 32'h1);

        // Rotation 0,1,2,3,0 with Req=1111 held
        for (int i = 0; i < 5; i++) begin
            idx     = i % 4;
            exp_gnt = 4'b0001 << idx;
            chk("rot_gnt", 32'(Gnt), 32'(exp_gnt));
            tick();
            chk("rot_sel",   32'(Sel),    32'(idx));
            chk("rot_wren",  32'(WrEn),   32'h1);
            chk("rot_waddr", 32'(WrAddr), 32'(idx + 1));
            chk("rot_wdata", WrData,      32'hA0 + 32'(idx));
        end
        chk("rot_ptr", 32'(dut.ptr_q), 32'h1);

        // Idle: no transfer, write port holds
        Req = 4'b0000;
        #1;
        chk("idle_gnt", 32'(Gnt), 32'h0);
        tick();
        chk("idle_wren",  32'(WrEn),   32'h0);
        chk("idle_sel",   32'(Sel),    32'h0);
        chk("idle_waddr", 32'(WrAddr), 32'h1);
        chk("idle_ptr",   32'(dut.ptr_q), 32'h1);

        // Single write from requester 2
        Req        = 4'b0100;
        ReqAddr[2] = 5'd9;
        ReqData[2] = 32'hDEADBEEF;
        #1;
        chk("single_gnt", 32'(Gnt), 32'h4);
        tick();
        Req = 4'b0000;
        chk("single_wren",  32'(WrEn),   32'h1);
        chk("single_waddr", 32'(WrAddr), 32'd9);
        chk("single_wdata", WrData,      32'hDEADBEEF);
        chk("single_sel",   32'(Sel),    32'h2);
        chk("single_ptr",   32'(dut.ptr_q), 32'h3);

        // Write to $zero from requester 1 (search wraps 3 -> 0 -> 1)
        Req        = 4'b0010;
        ReqAddr[1] = 5'd0;
        ReqData[1] = 32'h12345678;
        #1;
        chk("zero_gnt", 32'(Gnt), 32'h2);
        tick();
        Req = 4'b0000;
        chk("zero_wren",  32'(WrEn),   32'h0);
        chk("zero_ptr",   32'(dut.ptr_q), 32'h2);
        chk("zero_sel",   32'(Sel),    32'h1);
        chk("zero_wdata", WrData,      32'h12345678);
        ReqAddr[1] = 5'd2;

        // Stall for 3 cycles with requester 3 waiting
        Stall = 1'b1;
        Req   = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_gnt", 32'(Gnt), 32'h0);
            tick();
            chk("stall_wren", 32'(WrEn), 32'h0);
            chk("stall_ptr",  32'(dut.ptr_q), 32'h2);
        end
        Stall = 1'b0;
        #1;
        chk("unstall_gnt", 32'(Gnt), 32'h8);
        tick();
        chk("unstall_wren",  32'(WrEn),   32'h1);
        chk("unstall_sel",   32'(Sel),    32'h3);
        chk("unstall_waddr", 32'(WrAddr), 32'h4);
        chk("unstall_ptr",   32'(dut.ptr_q), 32'h0);

        // Priority from ptr=0 picks 1 over 3; then 3 with ptr=2
        Req = 4'b1010;
        #1;
        chk("prio_gnt1", 32'(Gnt), 32'h2);
        tick();
        chk("prio_ptr1", 32'(dut.ptr_q), 32'h2);
        Req = 4'b1000;
        #1;
        chk("prio_gnt2", 32'(Gnt), 32'h8);
        tick();
        Req = 4'b0000;
        chk("prio_sel2", 32'(Sel), 32'h3);
        chk("prio_ptr2", 32'(dut.ptr_q), 32'h0);

        // Reset asserted the cycle after a granted write
        Req = 4'b0001;
        #1;
        chk("mid_gnt", 32'(Gnt), 32'h1);
        tick();
        chk("mid_wren_pre", 32'(WrEn), 32'h1);
        chk("mid_ptr_pre",  32'(dut.ptr_q), 32'h1);
        Rst = 1'b0;
        #1;
        chk("mid_wren",  32'(WrEn),   32'h0);
        chk("mid_ptr",   32'(dut.ptr_q), 32'h0);
        chk("mid_sel",   32'(Sel),    32'h0);
        chk("mid_waddr", 32'(WrAddr), 32'h0);
        chk("mid_gnt_rst", 32'(Gnt),  32'h0);
        tick();
        Rst = 1'b1;
        #1;
        chk("resume_gnt", 32'(Gnt), 32'h1);
        tick();
        Req = 4'b0000;
        chk("resume_wren",  32'(WrEn),   32'h1);
        chk("resume_waddr", 32'(WrAddr), 32'h1);
        chk("resume_ptr",   32'(dut.ptr_q), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
